bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Parametrised MM:SS BCD countdown timer with keypad-style serial digit entry, start/pause/clear control, a second-tick prescaler and optional auto-reload. It is the next generation of the team's cascaded down-counter timer: the same four-digit display outputs, plus explicit run control, input validation, a one-cycle expiry pulse and a sticky finished flag. It sits between the keypad/button front-end and the 7-segment display driver.

## Interface
- TICK_DIV, 1: clk cycles per one-second decrement, ≥1; 1 for simulation, board value set at top level.
- MIN_TENS_MAX, 5: maximum minute-tens digit, 0..9; 9 gives a 99:59 range.
- AUTO_RELOAD, 0: 1 = restart from the start value on expiry; 0 = stop at 00:00.
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear to IDLE, all digits 0, flags 0.
- load  in  1  shift digit `in` into the display (IDLE/DONE only).
- in  in  4  BCD digit for entry.
- start  in  1  begin counting (IDLE) or resume (PAUSE).
- pause  in  1  suspend counting (RUN).
- out_second_unit, out_second_tens, out_minute_unit, out_minute_tens  out  4 each  current BCD value.
- running  out  1  high in RUN.
- finished  out  1  sticky expiry flag.
- done  out  1  one-cycle pulse per expiry.

## Operation
- States: IDLE, RUN, PAUSE, DONE. After reset: IDLE, all digits 0, running/finished/done 0, prescaler 0, reload register 0.
- Input priority per cycle: clear > load > pause > start.
- clear, any state: IDLE, digits 0, reload register 0, finished 0, prescaler 0.
- load, IDLE or DONE: digits shift left one place (min_tens←min_unit←sec_tens←sec_unit←in); min_tens old value is discarded. Values of `in` above 9 are stored as 9. From DONE, state becomes IDLE and finished clears. load is ignored in RUN and PAUSE.
- start, IDLE: clamp sec_tens to ≤5 and min_tens to ≤MIN_TENS_MAX on the same edge. Copy the clamped value into the reload register. Prescaler ← 0. If the clamped value is 00:00: go to DONE, finished←1, done pulses. Otherwise go to RUN.
- start, PAUSE: go to RUN. The prescaler keeps its value.
- start, RUN or DONE: ignored.
- pause, RUN: go to PAUSE. Digits and prescaler hold. Ignored in other states.
- Prescaler counts 0..TICK_DIV-1 only in RUN. The edge on which it equals TICK_DIV-1 is a tick: prescaler←0 and the value decrements by one second.
- Decrement is cascaded BCD borrow:
  - sec_unit 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_unit.
  - min_unit 0→9 borrows from min_tens.
  - The whole decrement happens on a single edge.
- Expiry: the tick whose result is 00:00 sets finished←1 and pulses done.
  - AUTO_RELOAD=0: state goes to DONE.
  - AUTO_RELOAD=1: state stays RUN with 00:00 shown for one tick period. The next tick loads the reload register instead of decrementing, and counting continues. finished stays set until clear, load-from-DONE or reset.
- DONE holds the digits at 00:00 and running=0.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- start sampled at edge E0 → RUN after E0. First decrement at edge E_TICK_DIV. Subsequent decrements every TICK_DIV edges.
- done is high for exactly the one cycle following the expiry edge, then returns to 0.
- running rises on the edge that enters RUN and falls on the edge that leaves it.
- pause then start with no clear: the remaining prescaler count is preserved, so total elapsed RUN cycles per second are exactly TICK_DIV.
- start and pause asserted in the same cycle while in PAUSE: stays in PAUSE (pause wins).
- rst asserted mid-count: all outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Entry: load digits 1,2,3,4 in IDLE → display 12:34. Then load 0xC → display 23:49.
- Clamp and count, TICK_DIV=1: load 0,1,9,9 then start → value clamps to 01:59. Next edges show 01:58, 01:57, … Borrow chain 01:00→00:59 is correct. Expiry at the 119th decrement: done high exactly 1 cycle, finished=1, state DONE, running=0.
- Pause and prescaler, TICK_DIV=4: start from 00:03, pause after 2 RUN cycles, hold pause 10 cycles (display unchanged), start → next decrement to 00:02 exactly 2 cycles after resume.
- Zero start: start with 00:00 → DONE next edge, done pulses once. load 5 → IDLE, finished=0, display 00:05.
- Auto-reload, AUTO_RELOAD=1, TICK_DIV=1: start 00:02 → 00:01, 00:00 (done pulse), 00:02, 00:01, 00:00 (done pulse). finished stays 1 until clear.
- Priority and reset: in RUN, assert clear and start together → IDLE, all zeros. Assert rst asynchronously mid-count → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: keypad digit entry, start/pause/clear control,
// one-second prescaler, optional auto-reload, expiry pulse and sticky finished flag.
module bcd_countdown_timer #(
   parameter int TICK_DIV     = 1,
   parameter int MIN_TENS_MAX = 5,
   parameter int AUTO_RELOAD  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] in,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] out_second_unit,
   output logic [3:0] out_second_tens,
   output logic [3:0] out_minute_unit,
   output logic [3:0] out_minute_tens,
   output logic       running,
   output logic       finished,
   output logic       done
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

   state_e        state_q;
   logic [3:0]    secUnit_q, secTens_q, minUnit_q, minTens_q;
   logic [15:0]   reload_q;
   logic [PW-1:0] presc_q;
   logic          running_q, finished_q, done_q;

   logic [3:0] secUnitDec, secTensDec, minUnitDec, minTensDec;
   logic [3:0] secTensClamp, minTensClamp, inSat;
   logic       tick, curZero, decZero, clampZero;

   // Cascaded BCD borrow: each digit wraps only when every lower digit wraps.
   always_comb begin
      secUnitDec = secUnit_q - 4'd1;
      secTensDec = secTens_q;
      minUnitDec = minUnit_q;
      minTensDec = minTens_q;
      if (secUnit_q == 4'd0) begin
         secUnitDec = 4'd9;
         if (secTens_q == 4'd0) begin
            secTensDec = 4'd5;
            if (minUnit_q == 4'd0) begin
               minUnitDec = 4'd9;
               minTensDec = minTens_q - 4'd1;
            end else begin
               minUnitDec = minUnit_q - 4'd1;
            end
         end else begin
            secTensDec = secTens_q - 4'd1;
         end
      end
   end

   assign secTensClamp = (secTens_q > 4'd5) ? 4'd5 : secTens_q;
   assign minTensClamp = (minTens_q > MT_MAX) ? MT_MAX : minTens_q;
   assign inSat        = (in > 4'd9) ? 4'd9 : in;
   assign tick         = (presc_q == PRESC_LAST);
   assign curZero      = ({minTens_q, minUnit_q, secTens_q, secUnit_q} == 16'd0);
   assign decZero      = ({minTensDec, minUnitDec, secTensDec, secUnitDec} == 16'd0);
   assign clampZero    = ({minTensClamp, minUnit_q, secTensClamp, secUnit_q} == 16'd0);

   // running is tracked as its own flop so every output comes straight from a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         secUnit_q  <= 4'd0;
         secTens_q  <= 4'd0;
         minUnit_q  <= 4'd0;
         minTens_q  <= 4'd0;
         reload_q   <= 16'd0;
         presc_q    <= '0;
         running_q  <= 1'b0;
         finished_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (clear) begin
            state_q    <= IDLE;
            secUnit_q  <= 4'd0;
            secTens_q  <= 4'd0;
            minUnit_q  <= 4'd0;
            minTens_q  <= 4'd0;
            reload_q   <= 16'd0;
            presc_q    <= '0;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
         end else if (load && (state_q == IDLE || state_q == DONE)) begin
            minTens_q  <= minUnit_q;
            minUnit_q  <= secTens_q;
            secTens_q  <= secUnit_q;
            secUnit_q  <= inSat;
            state_q    <= IDLE;
            finished_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     secTens_q <= secTensClamp;
                     minTens_q <= minTensClamp;
                     reload_q  <= {minTensClamp, minUnit_q, secTensClamp, secUnit_q};
                     presc_q   <= '0;
                     if (clampZero) begin
                        state_q    <= DONE;
                        finished_q <= 1'b1;
                        done_q     <= 1'b1;
                     end else begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (pause) begin
                     state_q   <= PAUSE;
                     running_q <= 1'b0;
                  end else if (tick) begin
                     presc_q <= '0;
                     // A zero value can only be seen here with auto-reload: restart the period.
                     if (AUTO_RELOAD != 0 && curZero) begin
                        {minTens_q, minUnit_q, secTens_q, secUnit_q} <= reload_q;
                     end else begin
                        {minTens_q, minUnit_q, secTens_q, secUnit_q} <=
                           {minTensDec, minUnitDec, secTensDec, secUnitDec};
                        if (decZero) begin
                           finished_q <= 1'b1;
                           done_q     <= 1'b1;
                           if (AUTO_RELOAD == 0) begin
                              state_q   <= DONE;
                              running_q <= 1'b0;
                           end
                        end
                     end
                  end else begin
                     presc_q <= presc_q + PW'(1);
                  end
               end
               PAUSE: begin
                  if (start && !pause) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign out_second_unit = secUnit_q;
   assign out_second_tens = secTens_q;
   assign out_minute_unit = minUnit_q;
   assign out_minute_tens = minTens_q;
   assign running         = running_q;
   assign finished        = finished_q;
   assign done            = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: three parameterisations share one stimulus
// stream and are each compared every cycle against a seconds-based reference model.
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       rst, clear, load, start, pause;
   logic [3:0] din;

   logic [3:0] oSu[3], oSt[3], oMu[3], oMt[3];
   logic       oRun[3], oFin[3], oDone[3];

   int checks = 0;
   int errors = 0;

   // Clock generation, 10 time-unit period.
   always #5 clk = ~clk;

   bcd_countdown_timer #(.TICK_DIV(1), .MIN_TENS_MAX(5), .AUTO_RELOAD(0)) dut0 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .in(din), .start(start), .pause(pause),
      .out_second_unit(oSu[0]), .out_second_tens(oSt[0]), .out_minute_unit(oMu[0]),
      .out_minute_tens(oMt[0]), .running(oRun[0]), .finished(oFin[0]), .done(oDone[0]));

   bcd_countdown_timer #(.TICK_DIV(4), .MIN_TENS_MAX(5), .AUTO_RELOAD(0)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .in(din), .start(start), .pause(pause),
      .out_second_unit(oSu[1]), .out_second_tens(oSt[1]), .out_minute_unit(oMu[1]),
      .out_minute_tens(oMt[1]), .running(oRun[1]), .finished(oFin[1]), .done(oDone[1]));

   bcd_countdown_timer #(.TICK_DIV(1), .MIN_TENS_MAX(9), .AUTO_RELOAD(1)) dut2 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .in(din), .start(start), .pause(pause),
      .out_second_unit(oSu[2]), .out_second_tens(oSt[2]), .out_minute_unit(oMu[2]),
      .out_minute_tens(oMt[2]), .running(oRun[2]), .finished(oFin[2]), .done(oDone[2]));

   // Reference model: the value lives as a plain number of seconds while counting.
   int tdv[3];
   int mtv[3];
   int arv[3];
   int mState[3];
   int mDig[3][4];
   int mReload[3];
   int mCnt[3];
   bit mFin[3];
   bit mDone[3];

   typedef struct {
      bit          c;
      bit          l;
      logic [3:0]  d;
      bit          s;
      bit          p;
      logic [18:0] exp;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [18:0] mk(input logic [15:0] dg, input logic r, input logic f, input logic dn);
      return {dg, r, f, dn};
   endfunction

   function automatic int toSec(input int mt, input int mu, input int st, input int su);
      return mt * 600 + mu * 60 + st * 10 + su;
   endfunction

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [18:0] dutVec(input int i);
      return {oMt[i], oMu[i], oSt[i], oSu[i], oRun[i], oFin[i], oDone[i]};
   endfunction

   function automatic logic [18:0] modelVec(input int i);
      return {4'(mDig[i][0]), 4'(mDig[i][1]), 4'(mDig[i][2]), 4'(mDig[i][3]),
              (mState[i] == 1), mFin[i], mDone[i]};
   endfunction

   task automatic setSec(input int i, input int s);
      mDig[i][0] = s / 600;
      mDig[i][1] = (s / 60) % 10;
      mDig[i][2] = (s % 60) / 10;
      mDig[i][3] = s % 10;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mState[i] = 0;
         for (int k = 0; k < 4; k++) mDig[i][k] = 0;
         mReload[i] = 0;
         mCnt[i] = 0;
         mFin[i] = 1'b0;
         mDone[i] = 1'b0;
      end
   endtask

   // States: 0 idle, 1 run, 2 pause, 3 done.
   task automatic modelStep(input bit c, input bit l, input int d, input bit s, input bit p);
      int sec;
      for (int i = 0; i < 3; i++) begin
         mDone[i] = 1'b0;
         if (c) begin
            mState[i] = 0;
            for (int k = 0; k < 4; k++) mDig[i][k] = 0;
            mReload[i] = 0;
            mCnt[i] = 0;
            mFin[i] = 1'b0;
         end else if (l && (mState[i] == 0 || mState[i] == 3)) begin
            mDig[i][0] = mDig[i][1];
            mDig[i][1] = mDig[i][2];
            mDig[i][2] = mDig[i][3];
            mDig[i][3] = minInt(d, 9);
            mState[i] = 0;
            mFin[i] = 1'b0;
         end else if (mState[i] == 0) begin
            if (s) begin
               sec = toSec(minInt(mDig[i][0], mtv[i]), mDig[i][1], minInt(mDig[i][2], 5), mDig[i][3]);
               setSec(i, sec);
               mReload[i] = sec;
               mCnt[i] = 0;
               if (sec == 0) begin
                  mState[i] = 3;
                  mFin[i] = 1'b1;
                  mDone[i] = 1'b1;
               end else begin
                  mState[i] = 1;
               end
            end
         end else if (mState[i] == 1) begin
            if (p) begin
               mState[i] = 2;
            end else begin
               mCnt[i]++;
               if (mCnt[i] == tdv[i]) begin
                  mCnt[i] = 0;
                  sec = toSec(mDig[i][0], mDig[i][1], mDig[i][2], mDig[i][3]);
                  if (sec == 0) begin
                     sec = mReload[i];
                  end else begin
                     sec--;
                     if (sec == 0) begin
                        mFin[i] = 1'b1;
                        mDone[i] = 1'b1;
                        if (arv[i] == 0) mState[i] = 3;
                     end
                  end
                  setSec(i, sec);
               end
            end
         end else if (mState[i] == 2) begin
            if (s && !p) mState[i] = 1;
         end
      end
   endtask

   task automatic checkValue(input string name, input logic [18:0] act, input logic [18:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      for (int i = 0; i < 3; i++)
         checkValue($sformatf("%s dut%0d", name, i), dutVec(i), modelVec(i));
   endtask

   // Drive one cycle of inputs, advance the model on the edge, compare #1 later.
   task automatic applyStimulus(input bit c, input bit l, input logic [3:0] d, input bit s, input bit p);
      clear = c;
      load  = l;
      din   = d;
      start = s;
      pause = p;
      @(posedge clk);
      modelStep(c, l, int'(d), s, p);
      #1;
      checkOutput("model");
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin
      tdv = '{1, 4, 1};
      mtv = '{5, 5, 9};
      arv = '{0, 0, 1};

      tbl[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0)};
      tbl[1]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0)};
      tbl[2]  = '{1'b0, 1'b1, 4'd2,  1'b0, 1'b0, mk(16'h0012, 1'b0, 1'b0, 1'b0)};
      tbl[3]  = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b0, mk(16'h0123, 1'b0, 1'b0, 1'b0)};
      tbl[4]  = '{1'b0, 1'b1, 4'd4,  1'b0, 1'b0, mk(16'h1234, 1'b0, 1'b0, 1'b0)};
      tbl[5]  = '{1'b0, 1'b1, 4'hC,  1'b0, 1'b0, mk(16'h2349, 1'b0, 1'b0, 1'b0)};
      tbl[6]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0)};
      tbl[7]  = '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0)};
      tbl[8]  = '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0)};
      tbl[9]  = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, mk(16'h0019, 1'b0, 1'b0, 1'b0)};
      tbl[10] = '{1'b0, 1'b1, 4'd9,  1'b0, 1'b0, mk(16'h0199, 1'b0, 1'b0, 1'b0)};
      tbl[11] = '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, mk(16'h0159, 1'b1, 1'b0, 1'b0)};
      tbl[12] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, mk(16'h0158, 1'b1, 1'b0, 1'b0)};
      tbl[13] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, mk(16'h0157, 1'b1, 1'b0, 1'b0)};

      // Reset state.
      rst = 1'b1; clear = 1'b0; load = 1'b0; din = 4'd0; start = 1'b0; pause = 1'b0;
      modelReset();
      #2;
      checkOutput("reset");
      @(negedge clk);
      rst = 1'b0;

      // Entry, saturation, clamp and the first decrements.
      for (int k = 0; k < 14; k++) begin
         applyStimulus(tbl[k].c, tbl[k].l, tbl[k].d, tbl[k].s, tbl[k].p);
         checkValue($sformatf("vec%0d", k), dutVec(0), tbl[k].exp);
      end

      // Count 01:57 down to expiry, watching the minute borrow and the done pulse.
      for (int n = 3; n <= 119; n++) begin
         idle();
         if (n == 59)  checkValue("at0100", dutVec(0), mk(16'h0100, 1'b1, 1'b0, 1'b0));
         if (n == 60)  checkValue("borrow0059", dutVec(0), mk(16'h0059, 1'b1, 1'b0, 1'b0));
         if (n == 118) checkValue("at0001", dutVec(0), mk(16'h0001, 1'b1, 1'b0, 1'b0));
         if (n == 119) checkValue("expiry", dutVec(0), mk(16'h0000, 1'b0, 1'b1, 1'b1));
      end
      idle();
      checkValue("donePulseEnd", dutVec(0), mk(16'h0000, 1'b0, 1'b1, 1'b0));

      // Pause keeps the partial prescaler count on the TICK_DIV=4 instance.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      idle();
      idle();
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
         checkValue("pauseHold", dutVec(1), mk(16'h0003, 1'b0, 1'b0, 1'b0));
      end
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      checkValue("resume", dutVec(1), mk(16'h0003, 1'b1, 1'b0, 1'b0));
      idle();
      checkValue("resume+1", dutVec(1), mk(16'h0003, 1'b1, 1'b0, 1'b0));
      idle();
      checkValue("resume+2", dutVec(1), mk(16'h0002, 1'b1, 1'b0, 1'b0));

      // Zero start goes straight to DONE; a load leaves DONE.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      checkValue("zeroStart", dutVec(0), mk(16'h0000, 1'b0, 1'b1, 1'b1));
      idle();
      checkValue("zeroStartPulse", dutVec(0), mk(16'h0000, 1'b0, 1'b1, 1'b0));
      applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
      checkValue("loadFromDone", dutVec(0), mk(16'h0005, 1'b0, 1'b0, 1'b0));

      // Auto-reload sequence on the third instance.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      checkValue("ar0", dutVec(2), mk(16'h0002, 1'b1, 1'b0, 1'b0));
      idle(); checkValue("ar1", dutVec(2), mk(16'h0001, 1'b1, 1'b0, 1'b0));
      idle(); checkValue("ar2", dutVec(2), mk(16'h0000, 1'b1, 1'b1, 1'b1));
      idle(); checkValue("ar3", dutVec(2), mk(16'h0002, 1'b1, 1'b1, 1'b0));
      idle(); checkValue("ar4", dutVec(2), mk(16'h0001, 1'b1, 1'b1, 1'b0));
      idle(); checkValue("ar5", dutVec(2), mk(16'h0000, 1'b1, 1'b1, 1'b1));
      idle(); checkValue("ar6", dutVec(2), mk(16'h0002, 1'b1, 1'b1, 1'b0));
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      checkValue("arClear", dutVec(2), mk(16'h0000, 1'b0, 1'b0, 1'b0));

      // Priority: pause beats start in PAUSE, clear beats start in RUN.
      applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      checkValue("pauseWins", dutVec(0), mk(16'h0004, 1'b0, 1'b0, 1'b0));
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      checkValue("resumeRun", dutVec(0), mk(16'h0004, 1'b1, 1'b0, 1'b0));
      idle();
      checkValue("resumeDec", dutVec(0), mk(16'h0003, 1'b1, 1'b0, 1'b0));
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
      checkValue("clearWins", dutVec(0), mk(16'h0000, 1'b0, 1'b0, 1'b0));

      // Asynchronous reset while counting.
      applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      idle();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++)
         checkValue($sformatf("asyncReset dut%0d", i), dutVec(i), 19'd0);
      modelReset();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic against the model.
      for (int k = 0; k < 800; k++) begin
         applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
